i2c_smb_alert_rsp: RTL
======================

// Module: i2c_smb_alert_rsp
// PURPOSE
//  SMBus device-side alert responder, the other end of the host-side SMBALERT# sampling and
//  alert flagging. On software request it pulls SMBALERT# low, watches the bus for a read of
//  the Alert Response Address (ARA), ACKs it, then returns its own address with bit-wise
//  arbitration. On winning it releases SMBALERT#. Sits beside the slave engine on the same pins.
// PARAMETERS
//  ARA_ADDR   7'h0C  Alert Response Address matched by the address phase
//  RSP_LSB    1'b0   bit0 of the returned address byte
// PORTS
//  clk_i            in   1  system clock
//  rstn_i           in   1  async reset, active low
//  rw_smbus_i       in   1  SMBus mode enable; 0 = block held idle (sync clear)
//  rw_alert_i       in   1  software alert request level
//  rw_oar_i         in   7  own 7-bit slave address returned on ARA read
//  scl_i            in   1  raw SCL pin input
//  sda_i            in   1  raw SDA pin input
//  sda_oe_o         out  1  1 = drive SDA low (open drain)
//  smb_alert_oe_o   out  1  1 = drive SMBALERT# low
//  alert_done_o     out  1  1-cycle pulse: arbitration won, alert cleared
//  alert_arlo_o     out  1  1-cycle pulse: arbitration lost during address return
//  busy_o           out  1  FSM outside IDLE/ALERT
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, sync flops 1 (bus released).
//  - SCL/SDA: 2-flop sync; edges from synced vs previous sample. START = SDA fall while SCL 1;
//    STOP = SDA rise while SCL 1. SDA sampled on SCL rise; sda_oe_o changes cycle after SCL fall.
//  - FSM: IDLE -> ALERT when rw_alert_i=1 (smb_alert_oe_o=1 from next cycle).
//    ALERT: rw_alert_i=0 -> IDLE next cycle, alert released; START -> ADDR.
//    ADDR: shift 8 bits MSB first; on 8th rise compare {ARA_ADDR,1'b1}. Match -> AACK, else -> ALERT
//      (waits for STOP/next START, SDA never driven).
//    AACK: drive SDA low for 9th SCL pulse; release on its falling edge -> DATA.
//    DATA: send {rw_oar_i,RSP_LSB} MSB first (bit=0 drives low, bit=1 releases). On each rise, if
//      driven bit=1 but sampled 0 -> alert_arlo_o pulse, SDA released at once, -> ALERT.
//    MACK: after 8th bit release SDA; 9th rise ends byte (ACK/NACK ignored) -> alert_done_o pulse,
//      smb_alert_oe_o=0, -> IDLE.
//  - Address latched at entry to DATA; rw_oar_i changes mid-byte ignored.
//  - rw_alert_i dropping in AACK/DATA/MACK: response completes; done still pulses.
//  - STOP in any state: SDA released, -> ALERT if rw_alert_i else IDLE. Repeated START in any state -> ADDR.
//  - rw_smbus_i=0: sync return to IDLE, all outputs 0 next cycle, mid-byte abort allowed.
//  - Async reset mid-transfer: SDA/SMBALERT# released immediately.
//  - Bit counter 3 bits, wraps only via explicit reload at byte start.
// CONFIGURATION
//  I2C_ALERT_GLITCH_FLT_EN defined: 3-sample majority filter after sync on SCL and SDA; +1 cycle
//   edge latency, pulses of 1 clk rejected. Undefined: raw 2-flop sync only, no extra latency.
// STRUCTURE
//  - Shared package i2c_pkg: FSM state localparams (IDLE,ALERT,ADDR,AACK,DATA,MACK), ARA default
//    7'h0C, bus-event struct/typedef {start,stop,scl_rise,scl_fall,sda}.
//  - Sub-module i2c_bus_mon: sync, optional filter, START/STOP/SCL edge detect; reusable by
//    slave engine. FSM, shifter and arbitration live in top.
// TESTING
//  1 rw_alert_i=1 -> smb_alert_oe_o=1 next cycle; drop request in ALERT -> 0 next cycle.
//  2 START, host reads 0x19 (ARA+R), rw_oar_i=7'h3A -> ACK low on 9th clk, byte 0x74 driven,
//    host NACK -> alert_done_o 1 pulse, smb_alert_oe_o=0, busy_o=0.
//  3 Competing device returns 0x30 vs own 0x3A: bit4 (own 1, bus 0) -> alert_arlo_o pulse,
//    sda_oe_o=0, smb_alert_oe_o stays 1; next ARA read with no competitor -> done.
//  4 Host addresses 0x50 read -> no ACK, sda_oe_o never 1; STOP -> remains ALERT.
//  5 STOP injected mid-DATA bit3 -> sda_oe_o=0 same cycle+1, state ALERT; rw_smbus_i=0 -> IDLE.
//  6 FLT_EN build: 1-cycle SDA low glitch with SCL high -> no START; non-FLT build detects START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C/SMBus definitions: FSM state codes,
// default Alert Response Address and bus-event bundle.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALERT = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_AACK  = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_MACK  = 3'd5;

  localparam logic [6:0] ARA_DEFAULT = 7'h0C;

  typedef struct packed {
    logic start;
    logic stop;
    logic scl_rise;
    logic scl_fall;
    logic sda;
  } bus_evt_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_mon.sv
// SCL/SDA synchronizer and START/STOP/SCL-edge detector.
// I2C_ALERT_GLITCH_FLT_EN adds a 3-sample majority filter.
module i2c_bus_mon
  import i2c_pkg::*;
(
  input  logic     clk_i,
  input  logic     rstn_i,
  input  logic     scl_i,
  input  logic     sda_i,
  output bus_evt_t evt
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_cur;
  logic       sda_cur;
  logic       scl_prev;
  logic       sda_prev;

  // two-flop synchronizers, reset to released bus
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_ALERT_GLITCH_FLT_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;

  // history for majority vote over three samples
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end

  assign scl_cur = maj3({scl_hist, scl_sync[1]});
  assign sda_cur = maj3({sda_hist, sda_sync[1]});
`else
  assign scl_cur = scl_sync[1];
  assign sda_cur = sda_sync[1];
`endif

  // previous sample for edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  // SDA transitions while SCL stays high mark START/STOP
  always_comb begin
    evt          = '0;
    evt.start    = scl_cur & scl_prev
                 & sda_prev & ~sda_cur;
    evt.stop     = scl_cur & scl_prev
                 & ~sda_prev & sda_cur;
    evt.scl_rise = scl_cur & ~scl_prev;
    evt.scl_fall = ~scl_cur & scl_prev;
    evt.sda      = sda_cur;
  end

endmodule

// File: rtl/i2c_smb_alert_rsp.sv
// SMBus device-side alert responder: SMBALERT#, ARA ACK,
// address return with arbitration. I2C_ALERT_GLITCH_FLT_EN.
module i2c_smb_alert_rsp
  import i2c_pkg::*;
#(
  parameter logic [6:0] ARA_ADDR = ARA_DEFAULT,
  parameter logic       RSP_LSB  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rw_smbus_i,
  input  logic       rw_alert_i,
  input  logic [6:0] rw_oar_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       smb_alert_oe_o,
  output logic       alert_done_o,
  output logic       alert_arlo_o,
  output logic       busy_o
);

  bus_evt_t evt;

  logic [2:0] state, n_state;
  logic [6:0] sh, n_sh;
  logic [7:0] tx, n_tx;
  logic [2:0] cnt, n_cnt;
  logic       ph, n_ph;
  logic       n_sda_oe;
  logic       n_done;
  logic       n_arlo;

  i2c_bus_mon u_mon (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .evt    (evt)
  );

  // next-state: bus events override, then per-state bit handling
  always_comb begin
    n_state  = state;
    n_sh     = sh;
    n_tx     = tx;
    n_cnt    = cnt;
    n_ph     = ph;
    n_sda_oe = sda_oe_o;
    n_done   = 1'b0;
    n_arlo   = 1'b0;
    if (!rw_smbus_i) begin
      n_state  = ST_IDLE;
      n_sda_oe = 1'b0;
      n_cnt    = 3'd0;
      n_ph     = 1'b0;
    end else if (evt.stop) begin
      n_sda_oe = 1'b0;
      n_state  = rw_alert_i ? ST_ALERT : ST_IDLE;
    end else if (evt.start && state != ST_IDLE) begin
      n_state  = ST_ADDR;
      n_sda_oe = 1'b0;
      n_cnt    = 3'd0;
      n_sh     = 7'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rw_alert_i) n_state = ST_ALERT;
        end
        ST_ALERT: begin
          if (!rw_alert_i) n_state = ST_IDLE;
        end
        ST_ADDR: begin
          if (evt.scl_rise) begin
            n_sh = {sh[5:0], evt.sda};
            if (cnt == 3'd7) begin
              if ({sh, evt.sda} == {ARA_ADDR, 1'b1}) begin
                n_state = ST_AACK;
                n_ph    = 1'b0;
              end else begin
                n_state = ST_ALERT;
              end
            end else begin
              n_cnt = cnt + 3'd1;
            end
          end
        end
        ST_AACK: begin
          if (evt.scl_fall) begin
            if (ph) begin
              n_state  = ST_DATA;
              n_tx     = {rw_oar_i, RSP_LSB};
              n_sda_oe = ~rw_oar_i[6];
              n_cnt    = 3'd0;
            end else begin
              n_sda_oe = 1'b1;
            end
          end else if (evt.scl_rise) begin
            n_ph = 1'b1;
          end
        end
        ST_DATA: begin
          if (evt.scl_rise) begin
            if (tx[7] && !evt.sda) begin
              n_arlo   = 1'b1;
              n_sda_oe = 1'b0;
              n_state  = ST_ALERT;
            end else if (cnt == 3'd7) begin
              n_state = ST_MACK;
            end else begin
              n_cnt = cnt + 3'd1;
            end
          end else if (evt.scl_fall) begin
            n_tx     = {tx[6:0], 1'b0};
            n_sda_oe = ~tx[6];
          end
        end
        ST_MACK: begin
          if (evt.scl_fall) begin
            n_sda_oe = 1'b0;
          end else if (evt.scl_rise) begin
            n_done  = 1'b1;
            n_state = ST_IDLE;
          end
        end
        default: begin
          n_state  = ST_IDLE;
          n_sda_oe = 1'b0;
        end
      endcase
    end
  end

  // state, shifters and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= ST_IDLE;
      sh             <= 7'd0;
      tx             <= 8'd0;
      cnt            <= 3'd0;
      ph             <= 1'b0;
      sda_oe_o       <= 1'b0;
      smb_alert_oe_o <= 1'b0;
      alert_done_o   <= 1'b0;
      alert_arlo_o   <= 1'b0;
    end else begin
      state          <= n_state;
      sh             <= n_sh;
      tx             <= n_tx;
      cnt            <= n_cnt;
      ph             <= n_ph;
      sda_oe_o       <= n_sda_oe;
      smb_alert_oe_o <= (n_state != ST_IDLE);
      alert_done_o   <= n_done;
      alert_arlo_o   <= n_arlo;
    end
  end

  assign busy_o = (state != ST_IDLE)
               && (state != ST_ALERT);

endmodule
